pulse_burst_gen_8_bit: RTL and testbench
========================================

Name: pulse_burst_gen_8_bit

Overview:
Transmit-side companion to the 8-bit one-run edge counter. On a start request it emits exactly N square pulses on pulse_out, each with a programmable high and low time in qzt_clk cycles, then signals completion. Used to drive counter inputs, and to emulate encoder/mouse step streams, from the board quartz clock.

Parameters:
CNT_W, 8, width of pulse-count input and sent counter
PER_W, 8, width of half-period input and phase timer

Ports:
qzt_clk  input  1  board quartz clock; all registers update on its falling edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level input; a 0->1 transition sampled on qzt_clk launches a burst
abort  input  1  level input; when high, any burst in progress is cancelled
count  input  CNT_W  number of pulses to emit; latched at launch
half_period  input  PER_W  high time = low time, in qzt_clk cycles; latched at launch
pulse_out  output  1  generated pulse train
busy  output  1  high while a burst is in progress
done  output  1  one-cycle strobe at normal burst completion
sent  output  CNT_W  number of pulses emitted so far, counted at each rising edge of pulse_out

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; pulse_out=0, busy=0, done=0, sent=0; internal start_old=0; latches and timer cleared.
- Start detection: start_old registers start every cycle. A launch occurs when !start_old & start & !abort in IDLE or DONE. A start edge while busy is ignored; it is not queued.
- Launch cycle: latch N=count and H=max(half_period,1). Clear sent.
  - N=0: go to DONE. done=1 for one cycle; pulse_out stays 0.
  - N>0: go to HIGH. pulse_out=1, busy=1, sent=1, timer=H-1. pulse_out rises on the first falling edge after the start edge is sampled.
- HIGH: the timer decrements each cycle. When the timer is 0, go to LOW with pulse_out=0 and timer=H-1.
- LOW: the timer decrements each cycle. When the timer is 0:
  - sent<N: go to HIGH with pulse_out=1, sent=sent+1, timer=H-1.
  - sent==N: go to DONE with busy=0 and done=1.
- DONE: lasts one cycle, then returns to IDLE with done=0. A start edge arriving in DONE is accepted and launches a burst.
- Pulse timing: each pulse is exactly H cycles high followed by H cycles low. Burst length from the first rising edge to done is 2*N*H cycles.
- sent saturates at N, cannot wrap, and holds its value in IDLE until the next launch.
- abort=1 in any state forces, on the next edge: IDLE, pulse_out=0, busy=0, done=0. sent keeps the partial count. abort has priority over a simultaneous start edge.
- count and half_period changes during a burst have no effect.
- rst_n asserted mid-burst clears everything immediately. After release, start_old=0, so a start held high launches on the first edge.
- States: IDLE, HIGH, LOW, DONE; 2-bit encoding.

Optional Feature:
PULSE_BURST_REPEAT_EN
- Defined: adds input port repeat (1 bit). If repeat=1 when LOW completes the last pulse, done still pulses for one cycle. The block then relaunches directly into HIGH with the latched N and H: sent=1, busy remains 1, no idle gap. abort stops the loop.
- Not defined: no repeat port; every burst is single-shot as described above.

Decomposition:
- Shared package pulse_gen_pkg holds the state encoding constants (ST_IDLE=0, ST_HIGH=1, ST_LOW=2, ST_DONE=3) and the CNT_W/PER_W defaults.
- Sub-module pulse_phase_timer: a loadable down-counter with a zero flag, instantiated once.
- Edge detection and the FSM live in the top module.

Test Plan:
1. count=3, half_period=2, start edge -> pulse_out high 2/low 2 x3; sent 1,2,3; done strobe one cycle after 12 cycles of burst; busy low with done.
2. count=0, start edge -> no pulse_out activity, done=1 for exactly one cycle, busy never high.
3. half_period=0, count=2 -> treated as H=1: pattern 1,0,1,0, then done.
4. count=5, H=3, abort raised after the 2nd rising edge -> pulse_out=0 next cycle, busy=0, sent=2, no done; a new start edge relaunches with sent restarting at 1.
5. Second start edge mid-burst with count changed from 4 to 9 -> ignored; exactly 4 pulses emitted.
6. rst_n pulsed low mid-HIGH (asynchronous, between clock edges) -> outputs 0 immediately; start held high through the release launches a burst on the first edge after release.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse burst generator: FSM state encoding
// and default widths for the pulse count and the half-period timer.
package pulse_gen_pkg;

    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned PER_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } pulse_state_t;

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one phase (high or low) of a pulse.
// Stops at zero and reports it with a zero flag. Updates on the falling
// edge of clk, like the rest of the generator.
module pulse_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    // Load has priority over decrement; the count holds once it reaches zero.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_burst_gen_8_bit.sv
// Pulse burst generator: on a start edge emits N square pulses of H cycles
// high and H cycles low on pulse_out, then strobes done.
// All registers update on the falling edge of qzt_clk.
// Optional macro PULSE_BURST_REPEAT_EN adds input repeat_en: when high at
// the end of a burst, done still strobes and the burst relaunches at once.
module pulse_burst_gen_8_bit
    import pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned PER_W = PER_W_DEF
) (
    input  logic             qzt_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    input  logic [PER_W-1:0] half_period,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent
`ifdef PULSE_BURST_REPEAT_EN
    // "repeat" is a reserved word, hence the suffix.
    ,
    input  logic             repeat_en
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);

    pulse_state_t     state_q, state_d;
    logic             start_old_q;
    logic             done_q, done_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [PER_W-1:0] h_q, h_d;

    logic             launch;
    logic [PER_W-1:0] h_launch;
    logic             tmr_load;
    logic [PER_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    // A half period of zero would give no pulse at all; run it as one cycle.
    assign h_launch = (half_period == '0) ? PER_ONE : half_period;

    // New bursts are accepted only from IDLE or DONE; abort blocks a launch.
    assign launch = !start_old_q && start && !abort
                    && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    pulse_phase_timer #(
        .W (PER_W)
    ) u_phase_timer (
        .clk      (qzt_clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State, edge-detect history, latched burst settings and output registers.
    always_ff @(negedge qzt_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_old_q <= 1'b0;
            done_q      <= 1'b0;
            sent_q      <= '0;
            n_q         <= '0;
            h_q         <= '0;
        end else begin
            state_q     <= state_d;
            start_old_q <= start;
            done_q      <= done_d;
            sent_q      <= sent_d;
            n_q         <= n_d;
            h_q         <= h_d;
        end
    end

    // Next-state logic: launch, phase sequencing, completion and abort.
    always_comb begin
        state_d      = state_q;
        done_d       = 1'b0;
        sent_d       = sent_q;
        n_d          = n_q;
        h_d          = h_q;
        tmr_load     = 1'b0;
        tmr_load_val = h_q - PER_ONE;
        tmr_dec      = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        n_d = count;
                        h_d = h_launch;
                        if (count == '0) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            sent_d  = '0;
                        end else begin
                            state_d      = ST_HIGH;
                            sent_d       = CNT_ONE;
                            tmr_load     = 1'b1;
                            tmr_load_val = h_launch - PER_ONE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_HIGH: begin
                    if (tmr_zero) begin
                        state_d  = ST_LOW;
                        tmr_load = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end

                ST_LOW: begin
                    if (tmr_zero) begin
                        if (sent_q < n_q) begin
                            state_d  = ST_HIGH;
                            sent_d   = sent_q + CNT_ONE;
                            tmr_load = 1'b1;
                        end else begin
                            done_d = 1'b1;
`ifdef PULSE_BURST_REPEAT_EN
                            // Relaunch straight into HIGH so busy never drops.
                            if (repeat_en) begin
                                state_d  = ST_HIGH;
                                sent_d   = CNT_ONE;
                                tmr_load = 1'b1;
                            end else begin
                                state_d = ST_DONE;
                            end
`else
                            state_d = ST_DONE;
`endif
                        end
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign pulse_out = (state_q == ST_HIGH);
    assign busy      = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign done      = done_q;
    assign sent      = sent_q;

endmodule

// File: tb/tb_pulse_burst_gen_8_bit.sv
// Self-checking bench for pulse_burst_gen_8_bit: directed vector table,
// hand-written multi-cycle sequences and randomized stimulus checked
// against a burst-position reference model.
module tb_pulse_burst_gen_8_bit;

    logic       qzt_clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] count;
    logic [7:0] half_period;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] sent;

    int tests_run = 0;
    int tests_failed = 0;

    pulse_burst_gen_8_bit #(
        .CNT_W (8),
        .PER_W (8)
    ) dut (
        .qzt_clk     (qzt_clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .count       (count),
        .half_period (half_period),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .sent        (sent)
`ifdef PULSE_BURST_REPEAT_EN
        ,
        .repeat_en   (1'b0)
`endif
    );

    initial qzt_clk = 1'b1;
    always #5 qzt_clk = ~qzt_clk;

    // Reference model: a burst is a position k (edges since launch) within
    // a 2*N*H window; outputs follow from k by arithmetic.
    int m_sold, m_active, m_k, m_n, m_h, m_hold;
    int e_pulse, e_busy, e_done, e_sent;

    task automatic model_reset();
        m_sold = 0; m_active = 0; m_k = 0; m_n = 0; m_h = 1; m_hold = 0;
        e_pulse = 0; e_busy = 0; e_done = 0; e_sent = 0;
    endtask

    task automatic model_step(input int s, input int a, input int c, input int h);
        int len;
        int in_done;
        len = 2 * m_n * m_h;
        in_done = (m_active != 0) && (m_k == len);
        if (a != 0) begin
            m_active = 0;
        end else if (m_sold == 0 && s != 0 && (m_active == 0 || in_done != 0)) begin
            m_active = 1; m_k = 0; m_n = c; m_h = (h == 0) ? 1 : h;
        end else if (m_active != 0) begin
            if (in_done != 0) m_active = 0;
            else m_k++;
        end
        m_sold = s;
        len = 2 * m_n * m_h;
        e_busy  = (m_active != 0) && (m_k < len);
        e_done  = (m_active != 0) && (m_k == len);
        e_pulse = (e_busy != 0) && ((m_k % (2 * m_h)) < m_h);
        if (e_busy != 0)      e_sent = m_k / (2 * m_h) + 1;
        else if (e_done != 0) e_sent = m_n;
        else                  e_sent = m_hold;
        m_hold = e_sent;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_pulse"}, int'(pulse_out), e_pulse);
        chk({tag, "_busy"},  int'(busy),      e_busy);
        chk({tag, "_done"},  int'(done),      e_done);
        chk({tag, "_sent"},  int'(sent),      e_sent);
    endtask

    // Drive inputs just after a rising edge, let the falling edge act,
    // then sample on the next rising edge.
    task automatic step(input logic s, input logic a, input logic [7:0] c,
                        input logic [7:0] h, input string tag);
        start = s; abort = a; count = c; half_period = h;
        model_step(int'(s), int'(a), int'(c), int'(h));
        @(negedge qzt_clk);
        @(posedge qzt_clk);
        cmp_model(tag);
    endtask

    typedef struct {
        logic       s;
        logic       a;
        logic [7:0] c;
        logic [7:0] h;
        logic       p;
        logic       b;
        logic       d;
        logic [7:0] sn;
    } vec_t;

    function automatic vec_t mk(input int s, input int a, input int c, input int h,
                                input int p, input int b, input int d, input int sn);
        vec_t v;
        v.s = s[0]; v.a = a[0]; v.c = c[7:0]; v.h = h[7:0];
        v.p = p[0]; v.b = b[0]; v.d = d[0]; v.sn = sn[7:0];
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        int   rises;
        int   seen;
        logic pp;

        // Burst of 3 pulses, H=2: 1100 x3 then done.
        vecs.push_back(mk(0,0,3,2, 0,0,0,0));
        vecs.push_back(mk(1,0,3,2, 1,1,0,1));
        vecs.push_back(mk(1,0,3,2, 1,1,0,1));
        vecs.push_back(mk(1,0,3,2, 0,1,0,1));
        vecs.push_back(mk(1,0,3,2, 0,1,0,1));
        vecs.push_back(mk(1,0,3,2, 1,1,0,2));
        vecs.push_back(mk(1,0,3,2, 1,1,0,2));
        vecs.push_back(mk(1,0,3,2, 0,1,0,2));
        vecs.push_back(mk(1,0,3,2, 0,1,0,2));
        vecs.push_back(mk(1,0,3,2, 1,1,0,3));
        vecs.push_back(mk(1,0,3,2, 1,1,0,3));
        vecs.push_back(mk(1,0,3,2, 0,1,0,3));
        vecs.push_back(mk(1,0,3,2, 0,1,0,3));
        vecs.push_back(mk(1,0,3,2, 0,0,1,3));
        vecs.push_back(mk(1,0,3,2, 0,0,0,3));
        // Zero-count burst: single done strobe, no busy.
        vecs.push_back(mk(0,0,0,2, 0,0,0,3));
        vecs.push_back(mk(1,0,0,2, 0,0,1,0));
        vecs.push_back(mk(1,0,0,2, 0,0,0,0));
        // Half period 0 runs as 1: 1,0,1,0 then done.
        vecs.push_back(mk(0,0,2,0, 0,0,0,0));
        vecs.push_back(mk(1,0,2,0, 1,1,0,1));
        vecs.push_back(mk(1,0,2,0, 0,1,0,1));
        vecs.push_back(mk(1,0,2,0, 1,1,0,2));
        vecs.push_back(mk(1,0,2,0, 0,1,0,2));
        vecs.push_back(mk(1,0,2,0, 0,0,1,2));
        vecs.push_back(mk(1,0,2,0, 0,0,0,2));

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; count = '0; half_period = '0;
        model_reset();
        #3;
        chk("reset_pulse", int'(pulse_out), 0);
        chk("reset_busy",  int'(busy),      0);
        chk("reset_done",  int'(done),      0);
        chk("reset_sent",  int'(sent),      0);
        @(posedge qzt_clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].s, vecs[i].a, vecs[i].c, vecs[i].h, "tbl_model");
            chk($sformatf("tbl%0d_pulse", i), int'(pulse_out), int'(vecs[i].p));
            chk($sformatf("tbl%0d_busy", i),  int'(busy),      int'(vecs[i].b));
            chk($sformatf("tbl%0d_done", i),  int'(done),      int'(vecs[i].d));
            chk($sformatf("tbl%0d_sent", i),  int'(sent),      int'(vecs[i].sn));
        end

        // Abort after the second rising edge, then relaunch.
        step(0, 0, 5, 3, "t4");
        step(1, 0, 5, 3, "t4");
        for (int i = 0; i < 6; i++) step(1, 0, 5, 3, "t4");
        chk("t4_second_pulse", int'(pulse_out), 1);
        step(1, 1, 5, 3, "t4");
        chk("t4_abort_pulse", int'(pulse_out), 0);
        chk("t4_abort_busy",  int'(busy),      0);
        chk("t4_abort_done",  int'(done),      0);
        chk("t4_abort_sent",  int'(sent),      2);
        step(0, 0, 5, 3, "t4");
        step(1, 0, 5, 3, "t4");
        chk("t4_relaunch_sent", int'(sent), 1);
        chk("t4_relaunch_busy", int'(busy), 1);
        step(1, 1, 5, 3, "t4");

        // Start edge mid-burst with a new count is ignored.
        step(0, 0, 4, 1, "t5");
        rises = 0; seen = 0; pp = 1'b0;
        step(1, 0, 4, 1, "t5");
        if (pulse_out && !pp) rises++;
        pp = pulse_out;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            if (i == 2)      step(0, 0, 9, 1, "t5");
            else if (i > 2)  step(1, 0, 9, 1, "t5");
            else             step(1, 0, 4, 1, "t5");
            if (pulse_out && !pp) rises++;
            pp = pulse_out;
            if (done) seen = 1;
        end
        chk("t5_done_seen", seen, 1);
        chk("t5_rises", rises, 4);
        chk("t5_sent", int'(sent), 4);

        // Asynchronous reset mid-HIGH, start held through release.
        step(0, 0, 3, 4, "t6");
        step(1, 0, 3, 4, "t6");
        step(1, 0, 3, 4, "t6");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_pulse", int'(pulse_out), 0);
        chk("t6_rst_busy",  int'(busy),      0);
        chk("t6_rst_sent",  int'(sent),      0);
        chk("t6_rst_done",  int'(done),      0);
        model_reset();
        #1 rst_n = 1'b1;
        model_step(1, 0, 3, 4);
        @(negedge qzt_clk);
        @(posedge qzt_clk);
        cmp_model("t6");
        chk("t6_launch_pulse", int'(pulse_out), 1);
        chk("t6_launch_sent",  int'(sent),      1);

        // Randomized stimulus against the model.
        for (int i = 0; i < 500; i++) begin
            logic       rs;
            logic       ra;
            logic [7:0] rc;
            logic [7:0] rh;
            rs = ($urandom_range(0, 3) != 0);
            ra = ($urandom_range(0, 24) == 0);
            rc = 8'($urandom_range(0, 6));
            rh = 8'($urandom_range(0, 4));
            step(rs, ra, rc, rh, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
